// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, flag bit positions, operand classes
// and the canonical quiet NaN.
package fpu_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam int unsigned FLAG_W         = 5;
  localparam int unsigned FLAG_INVALID   = 4;
  localparam int unsigned FLAG_OVERFLOW  = 3;
  localparam int unsigned FLAG_UNDERFLOW = 2;
  localparam int unsigned FLAG_INEXACT   = 1;
  localparam int unsigned FLAG_ZERO      = 0;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fpClass_e;

  // Canonical qNaN {0, exp all ones, frac MSB set}, right-aligned in 128 bits.
  function automatic logic [127:0] canonQnan(input int unsigned expW, input int unsigned manW);
    logic [127:0] ones;
    ones = (128'(1) << expW) - 128'(1);
    return (ones << manW) | (128'(1) << (manW - 1));
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational mantissa rounder shared by the FPU lanes: applies the rounding
// increment to {1,frac} and reports carry-out and inexact.
module fp_round
  import fpu_pkg::*;
#(
  parameter int unsigned MAN_W = 23
) (
  input  logic [MAN_W-1:0] frac,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sign,
  input  logic [1:0]       mode,
  output logic [MAN_W-1:0] roundFrac,
  output logic             carry,
  output logic             inexact
);

  localparam int unsigned SW = MAN_W + 2;

  logic          inc;
  logic [SW-1:0] mSum;

  always_comb begin
    inc = 1'b0;
    case (mode)
      RM_RNE:  inc = guard & (sticky | frac[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = (guard | sticky) & ~sign;
      default: inc = (guard | sticky) & sign;
    endcase
  end

  assign mSum      = {2'b01, frac} + SW'(inc);
  assign carry     = mSum[SW-1];
  assign roundFrac = carry ? mSum[MAN_W:1] : mSum[MAN_W-1:0];
  assign inexact   = guard | sticky;

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier lane with valid/ready on both sides, four
// rounding modes, flush-to-zero and exception flags.
module fp_mul_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1+EXP_W+MAN_W-1:0]     a,
  input  logic [1+EXP_W+MAN_W-1:0]     b,
  input  logic [1:0]                   round_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1+EXP_W+MAN_W-1:0]     result,
  output logic [4:0]                   flags
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned PW   = 2 * (MAN_W + 1);
  localparam int unsigned BIAS = 2 ** (EXP_W - 1) - 1;

  localparam logic [W-1:0]          QNAN        = W'(canonQnan(EXP_W, MAN_W));
  localparam logic [EXP_W-1:0]      EXP_ONES    = '1;
  localparam logic [EXP_W-1:0]      EXP_MAXFIN  = EXP_W'(2 ** EXP_W - 2);
  localparam logic signed [EW-1:0]  BIAS_S      = EW'(BIAS);
  localparam logic signed [EW-1:0]  EXP_OVF     = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0]  EXP_ZERO    = '0;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  function automatic fpClass_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return CLS_ZERO;
    if (e == EXP_ONES) return (f == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  // Operand capture: keeps the mantissa multiplier off the input pins.
  logic           s0Valid;
  logic [W-1:0]   s0A, s0B;
  logic [1:0]     s0Mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0Valid <= 1'b0;
      s0A     <= '0;
      s0B     <= '0;
      s0Mode  <= '0;
    end else if (advance) begin
      s0Valid <= in_valid;
      if (in_valid) begin
        s0A    <= a;
        s0B    <= b;
        s0Mode <= round_mode;
      end
    end
  end

  // S1: unpack, classify, exponent sum, mantissa product, special-case result.
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  fpClass_e           clsA, clsB;
  logic               signN;
  logic signed [EW-1:0] expSumN;
  logic [PW-1:0]      prodN;
  logic               specN;
  logic [W-1:0]       specResN;
  logic [FLAG_W-1:0]  specFlagsN;

  assign ea      = s0A[W-2 -: EXP_W];
  assign eb      = s0B[W-2 -: EXP_W];
  assign fa      = s0A[MAN_W-1:0];
  assign fb      = s0B[MAN_W-1:0];
  assign clsA    = classify(ea, fa);
  assign clsB    = classify(eb, fb);
  assign signN   = s0A[W-1] ^ s0B[W-1];
  assign expSumN = $signed(EW'(ea)) + $signed(EW'(eb)) - BIAS_S;
  assign prodN   = PW'({1'b1, fa}) * PW'({1'b1, fb});

  always_comb begin
    specN      = 1'b0;
    specResN   = '0;
    specFlagsN = '0;
    if (clsA == CLS_NAN || clsB == CLS_NAN) begin
      specN                    = 1'b1;
      specResN                 = QNAN;
      specFlagsN[FLAG_INVALID] = 1'b1;
    end else if ((clsA == CLS_INF && clsB == CLS_ZERO) || (clsA == CLS_ZERO && clsB == CLS_INF)) begin
      specN                    = 1'b1;
      specResN                 = QNAN;
      specFlagsN[FLAG_INVALID] = 1'b1;
    end else if (clsA == CLS_INF || clsB == CLS_INF) begin
      specN    = 1'b1;
      specResN = {signN, EXP_ONES, {MAN_W{1'b0}}};
    end else if (clsA == CLS_ZERO || clsB == CLS_ZERO) begin
      specN                 = 1'b1;
      specResN              = {signN, {(W-1){1'b0}}};
      specFlagsN[FLAG_ZERO] = 1'b1;
    end
  end

  logic                 s1Valid, s1Sign, s1Spec;
  logic signed [EW-1:0] s1Exp;
  logic [PW-1:0]        s1Prod;
  logic [1:0]           s1Mode;
  logic [W-1:0]         s1SpecRes;
  logic [FLAG_W-1:0]    s1SpecFlags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid     <= 1'b0;
      s1Sign      <= 1'b0;
      s1Spec      <= 1'b0;
      s1Exp       <= '0;
      s1Prod      <= '0;
      s1Mode      <= '0;
      s1SpecRes   <= '0;
      s1SpecFlags <= '0;
    end else if (advance) begin
      s1Valid <= s0Valid;
      if (s0Valid) begin
        s1Sign      <= signN;
        s1Spec      <= specN;
        s1Exp       <= expSumN;
        s1Prod      <= prodN;
        s1Mode      <= s0Mode;
        s1SpecRes   <= specResN;
        s1SpecFlags <= specFlagsN;
      end
    end
  end

  // S2: normalise the product to 1.x and split into fraction, guard, sticky.
  logic                 prodMsb;
  logic [PW-2:0]        prodNorm;
  logic signed [EW-1:0] expNormN;

  assign prodMsb  = s1Prod[PW-1];
  assign prodNorm = prodMsb ? s1Prod[PW-2:0] : {s1Prod[PW-3:0], 1'b0};
  assign expNormN = s1Exp + EW'(prodMsb);

  logic                 s2Valid, s2Sign, s2Spec, s2Guard, s2Sticky;
  logic signed [EW-1:0] s2Exp;
  logic [MAN_W-1:0]     s2Frac;
  logic [1:0]           s2Mode;
  logic [W-1:0]         s2SpecRes;
  logic [FLAG_W-1:0]    s2SpecFlags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid     <= 1'b0;
      s2Sign      <= 1'b0;
      s2Spec      <= 1'b0;
      s2Guard     <= 1'b0;
      s2Sticky    <= 1'b0;
      s2Exp       <= '0;
      s2Frac      <= '0;
      s2Mode      <= '0;
      s2SpecRes   <= '0;
      s2SpecFlags <= '0;
    end else if (advance) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Sign      <= s1Sign;
        s2Spec      <= s1Spec;
        s2Guard     <= prodNorm[MAN_W];
        s2Sticky    <= |prodNorm[MAN_W-1:0];
        s2Exp       <= expNormN;
        s2Frac      <= prodNorm[PW-2 -: MAN_W];
        s2Mode      <= s1Mode;
        s2SpecRes   <= s1SpecRes;
        s2SpecFlags <= s1SpecFlags;
      end
    end
  end

  // S3: round, detect overflow/underflow, pack into the output register.
  logic [MAN_W-1:0]     rndFrac;
  logic                 rndCarry, rndInexact;
  logic signed [EW-1:0] expFinal;
  logic [W-1:0]         resN, infRes, maxRes;
  logic [FLAG_W-1:0]    flagsN;

  fp_round #(.MAN_W(MAN_W)) uRound (
    .frac      (s2Frac),
    .guard     (s2Guard),
    .sticky    (s2Sticky),
    .sign      (s2Sign),
    .mode      (s2Mode),
    .roundFrac (rndFrac),
    .carry     (rndCarry),
    .inexact   (rndInexact)
  );

  assign expFinal = s2Exp + EW'(rndCarry);
  assign infRes   = {s2Sign, EXP_ONES, {MAN_W{1'b0}}};
  assign maxRes   = {s2Sign, EXP_MAXFIN, {MAN_W{1'b1}}};

  always_comb begin
    resN                 = {s2Sign, expFinal[EXP_W-1:0], rndFrac};
    flagsN               = '0;
    flagsN[FLAG_INEXACT] = rndInexact;
    if (s2Spec) begin
      resN   = s2SpecRes;
      flagsN = s2SpecFlags;
    end else if (expFinal >= EXP_OVF) begin
      flagsN[FLAG_OVERFLOW] = 1'b1;
      flagsN[FLAG_INEXACT]  = 1'b1;
      case (s2Mode)
        RM_RNE:  resN = infRes;
        RM_RTZ:  resN = maxRes;
        RM_RUP:  resN = s2Sign ? maxRes : infRes;
        default: resN = s2Sign ? infRes : maxRes;
      endcase
    end else if (expFinal <= EXP_ZERO) begin
      resN                   = {s2Sign, {(W-1){1'b0}}};
      flagsN[FLAG_UNDERFLOW] = 1'b1;
      flagsN[FLAG_INEXACT]   = 1'b1;
      flagsN[FLAG_ZERO]      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (advance) begin
      out_valid <= s2Valid;
      if (s2Valid) begin
        result <= resN;
        flags  <= flagsN;
      end
    end
  end

endmodule
